// File: rtl/bin2bcd_avalon_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_avalon_if
//  Avalon-MM slave bus bundle for the binary-to-BCD converter.
//  Signals:
//   avs_chipselect  slave select
//   avs_address     4-bit word address (0=DATA_IN, 1=STATUS, 2=RESULT)
//   avs_read        read strobe
//   avs_readdata    32-bit registered read data (driven by the slave)
//   avs_write       write strobe
//   avs_writedata   32-bit write data
//  Modports: slave (the converter), master (the Nios side / bench).
// ---------------------------------------------------------------------------
interface bin2bcd_avalon_if;
    logic        avs_chipselect;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    modport slave (
        input  avs_chipselect,
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );

    modport master (
        output avs_chipselect,
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );
endinterface

// File: rtl/bin2bcd_avalon.sv
// ---------------------------------------------------------------------------
// bin2bcd_avalon
//  Avalon-MM slave converting an unsigned binary value into 8 packed BCD
//  digits with a sequential double-dabble (one bit per clock). Leading zero
//  digits can be replaced by 4'hF, the display's blank code. Digit 7
//  (bits 31:28) is the leftmost display position.
//  Ports:
//   csi_clk         system clock
//   csi_reset_n     asynchronous active-low reset
//   avs             Avalon-MM slave bundle (bin2bcd_avalon_if.slave)
//   coe_oDIG        packed BCD/blank digits for the display
//   coe_oDIG_valid  one-cycle pulse when coe_oDIG updates
//  Register map: 0=DATA_IN (W), 1=STATUS (R, write-1-to-clear sticky bits),
//  2=RESULT (R). Other addresses read 0 and ignore writes.
// ---------------------------------------------------------------------------
module bin2bcd_avalon #(
    parameter int IN_W     = 27,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                   csi_clk,
    input  logic                   csi_reset_n,
    bin2bcd_avalon_if.slave        avs,
    output logic [31:0]            coe_oDIG,
    output logic                   coe_oDIG_valid
);
    localparam int          CNT_W   = 6;
    localparam logic [31:0] MAX_DEC = 32'd99_999_999;

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       bcd_q, bcd_d;
    logic [IN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              skip_q, skip_d;
    logic [IN_W-1:0]   dataIn_q, dataIn_d;
    logic [31:0]       result_q, result_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;
    logic [31:0]       readdata_q, readdata_d;

    logic              dataWr;
    logic              statusWr;
    logic              rdEn;
    logic [IN_W-1:0]   wrValue;
    logic              wrOverflow;
    logic [31:0]       bcdAdj;
    logic [31:0]       bcdBlanked;
    logic              leading;
    logic [31:0]       statusWord;
    logic              unusedBits;

    assign dataWr     = avs.avs_chipselect & avs.avs_write & (avs.avs_address == 4'd0);
    assign statusWr   = avs.avs_chipselect & avs.avs_write & (avs.avs_address == 4'd1);
    assign rdEn       = avs.avs_chipselect & avs.avs_read;
    assign wrValue    = avs.avs_writedata[IN_W-1:0];
    assign wrOverflow = 32'(wrValue) > MAX_DEC;
    assign statusWord = {28'd0, drop_q, ovf_q, done_q, (state_q != IDLE)};

    // Upper write-data bits and the top adjusted nibble bit are not needed by
    // the datapath; they are folded here so they are visibly consumed.
    assign unusedBits = (^avs.avs_writedata) ^ bcdAdj[31];

    assign coe_oDIG         = result_q;
    assign coe_oDIG_valid   = valid_q;
    assign avs.avs_readdata = readdata_q;

    // Double-dabble correction: any nibble of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    always_comb begin
        bcdAdj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: walk from the leftmost digit and blank zeros
    // until the first non-zero digit. Digit 0 always shows, so a value of 0
    // still displays a single "0".
    always_comb begin
        bcdBlanked = bcd_q;
        leading    = BLANK_LZ;
        for (int i = 7; i >= 1; i--) begin
            if (leading && (bcd_q[i*4 +: 4] == 4'd0)) begin
                bcdBlanked[i*4 +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
    end

    // Read mux: the value presented on the read edge is captured, so a
    // simultaneous STATUS read and clear returns the pre-clear bits.
    always_comb begin
        readdata_d = readdata_q;
        if (rdEn) begin
            case (avs.avs_address)
                4'd0:    readdata_d = 32'(dataIn_q);
                4'd1:    readdata_d = statusWord;
                4'd2:    readdata_d = result_q;
                default: readdata_d = 32'd0;
            endcase
        end
    end

    // Conversion FSM and status bookkeeping. Sticky-bit clears are applied
    // first so that a hardware set on the same edge wins. A DATA_IN write
    // is only accepted in IDLE; in SHIFT or FORMAT it is dropped.
    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        skip_d   = skip_q;
        dataIn_d = dataIn_q;
        result_d = result_q;
        valid_d  = 1'b0;
        done_d   = done_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (statusWr) begin
            if (avs.avs_writedata[1]) done_d = 1'b0;
            if (avs.avs_writedata[2]) ovf_d  = 1'b0;
            if (avs.avs_writedata[3]) drop_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (dataWr) begin
                    dataIn_d = wrValue;
                    bin_d    = wrValue;
                    bcd_d    = 32'd0;
                    cnt_d    = CNT_W'(IN_W);
                    skip_d   = wrOverflow;
                    done_d   = 1'b0;
                    ovf_d    = wrOverflow;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (dataWr) drop_d = 1'b1;
                if (!skip_q) begin
                    bcd_d = {bcdAdj[30:0], bin_q[IN_W-1]};
                    bin_d = bin_q << 1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FORMAT;
            end
            FORMAT: begin
                if (dataWr) drop_d = 1'b1;
                result_d = skip_q ? 32'hFFFF_FFFF : bcdBlanked;
                valid_d  = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update; reset blanks the display and aborts any
    // conversion in progress without a valid pulse.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state_q    <= IDLE;
            bcd_q      <= 32'd0;
            bin_q      <= '0;
            cnt_q      <= '0;
            skip_q     <= 1'b0;
            dataIn_q   <= '0;
            result_q   <= 32'hFFFF_FFFF;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            skip_q     <= skip_d;
            dataIn_q   <= dataIn_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            readdata_q <= readdata_d;
        end
    end
endmodule

// File: tb/tb_bin2bcd_avalon.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_avalon
//  Self-checking bench for bin2bcd_avalon. Two instances: one with leading
//  zero blanking (A) and one without (B). Expected digits come from a
//  decimal reference model using division/modulo on the integer value.
// ---------------------------------------------------------------------------
module tb_bin2bcd_avalon;
    localparam int IN_W = 27;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] digA, digB;
    logic        validA, validB;
    int          checks = 0;
    int          errors = 0;
    bit          expDrop = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_avalon_if busA ();
    bin2bcd_avalon_if busB ();

    bin2bcd_avalon #(.IN_W(IN_W), .BLANK_LZ(1'b1)) dut (
        .csi_clk        (clk),
        .csi_reset_n    (rstN),
        .avs            (busA.slave),
        .coe_oDIG       (digA),
        .coe_oDIG_valid (validA)
    );

    bin2bcd_avalon #(.IN_W(IN_W), .BLANK_LZ(1'b0)) dutNz (
        .csi_clk        (clk),
        .csi_reset_n    (rstN),
        .avs            (busB.slave),
        .coe_oDIG       (digB),
        .coe_oDIG_valid (validB)
    );

    // Reference: decimal digits by division; digits above the value's own
    // decimal length become blank when blanking is on.
    function automatic logic [31:0] refBcd(input logic [31:0] v, input bit blank);
        logic [31:0]     r;
        longint unsigned rem;
        int              nd;
        if (v > 32'd99_999_999) return 32'hFFFF_FFFF;
        r   = 32'd0;
        rem = v;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        nd  = 1;
        rem = v;
        while (rem >= 10) begin
            rem = rem / 10;
            nd++;
        end
        if (blank) begin
            for (int d = nd; d < 8; d++) r[d*4 +: 4] = 4'hF;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic driveBus(input bit selB, input logic cs, input logic rd, input logic wr,
                            input logic [3:0] addr, input logic [31:0] data);
        if (selB) begin
            busB.avs_chipselect = cs;
            busB.avs_read       = rd;
            busB.avs_write      = wr;
            busB.avs_address    = addr;
            busB.avs_writedata  = data;
        end else begin
            busA.avs_chipselect = cs;
            busA.avs_read       = rd;
            busA.avs_write      = wr;
            busA.avs_address    = addr;
            busA.avs_writedata  = data;
        end
    endtask

    // One-cycle write, launched on a falling edge, sampled on the rising edge.
    task automatic applyStimulus(input bit selB, input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        driveBus(selB, 1'b1, 1'b0, 1'b1, addr, data);
        @(negedge clk);
        driveBus(selB, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic busRead(input bit selB, input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        driveBus(selB, 1'b1, 1'b1, 1'b0, addr, 32'd0);
        @(negedge clk);
        driveBus(selB, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        data = selB ? busB.avs_readdata : busA.avs_readdata;
    endtask

    task automatic busReadWrite(input logic [3:0] addr, input logic [31:0] wdata,
                                output logic [31:0] data);
        @(negedge clk);
        driveBus(1'b0, 1'b1, 1'b1, 1'b1, addr, wdata);
        @(negedge clk);
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        data = busA.avs_readdata;
    endtask

    // Counts falling edges after the write edge until valid is seen; -1 on timeout.
    task automatic waitValid(input bit selB, input int startCyc, input int budget, output int cyc);
        cyc = -1;
        for (int c = startCyc + 1; c <= budget; c++) begin
            @(negedge clk);
            if ((selB ? validB : validA) === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic runConversion(input bit selB, input logic [31:0] v, input string tag);
        logic [31:0] rd;
        logic [31:0] exp;
        int          cyc;
        bit          ovf;
        ovf = (v > 32'd99_999_999);
        exp = refBcd(v, !selB);
        applyStimulus(selB, 4'd0, v);
        busRead(selB, 4'd1, rd);
        checkOutput({tag, " busy"}, rd, {28'd0, expDrop, ovf, 1'b0, 1'b1});
        waitValid(selB, 2, 60, cyc);
        checkOutput({tag, " latency"}, 32'(cyc), 32'(IN_W + 1));
        checkOutput({tag, " coe"}, selB ? digB : digA, exp);
        @(negedge clk);
        checkOutput({tag, " pulse"}, {31'd0, selB ? validB : validA}, 32'd0);
        busRead(selB, 4'd2, rd);
        checkOutput({tag, " result"}, rd, exp);
        busRead(selB, 4'd1, rd);
        checkOutput({tag, " status"}, rd, {28'd0, expDrop, ovf, 1'b1, 1'b0});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] v;
        int          cyc;
        int          pulses;

        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        driveBus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset coe", digA, 32'hFFFF_FFFF);
        checkOutput("reset valid", {31'd0, validA}, 32'd0);
        checkOutput("reset readdata", busA.avs_readdata, 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        busRead(1'b0, 4'd1, rd);
        checkOutput("reset status", rd, 32'd0);

        $display("[TB] T1/T2 directed conversions");
        runConversion(1'b0, 32'd12_345_678, "T1");
        runConversion(1'b0, 32'd0, "T2 zero");
        runConversion(1'b0, 32'd1000, "T2 1000");
        runConversion(1'b0, 32'd99_999_999, "T2 max");

        $display("[TB] T3 overflow");
        runConversion(1'b0, 32'd100_000_000, "T3");
        applyStimulus(1'b0, 4'd1, 32'h4);
        busRead(1'b0, 4'd1, rd);
        checkOutput("T3 ovf clear", rd, 32'h2);

        $display("[TB] T4 write while busy");
        applyStimulus(1'b0, 4'd0, 32'd5);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd7);
        waitValid(1'b0, 3, 60, cyc);
        checkOutput("T4 latency", 32'(cyc), 32'(IN_W + 1));
        checkOutput("T4 coe", digA, 32'hFFFF_FFF5);
        busRead(1'b0, 4'd1, rd);
        checkOutput("T4 status", rd, 32'hA);
        applyStimulus(1'b0, 4'd1, 32'h8);
        busRead(1'b0, 4'd1, rd);
        checkOutput("T4 drop clear", rd, 32'h2);
        busReadWrite(4'd1, 32'h2, rd);
        checkOutput("rdwr pre-clear", rd, 32'h2);
        busRead(1'b0, 4'd1, rd);
        checkOutput("rdwr post-clear", rd, 32'h0);

        $display("[TB] T5 reset mid-conversion");
        v = $urandom_range(0, 99_999_999);
        applyStimulus(1'b0, 4'd0, v);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("T5 coe", digA, 32'hFFFF_FFFF);
        checkOutput("T5 valid", {31'd0, validA}, 32'd0);
        checkOutput("T5 readdata", busA.avs_readdata, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (validA === 1'b1) pulses++;
        end
        checkOutput("T5 no pulse", 32'(pulses), 32'd0);
        busRead(1'b0, 4'd1, rd);
        checkOutput("T5 status", rd, 32'd0);
        runConversion(1'b0, $urandom_range(0, 99_999_999), "T5 after");

        $display("[TB] random conversions");
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(100_000_000, (1 << IN_W) - 1);
            else if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 9999);
            else v = $urandom_range(0, 99_999_999);
            runConversion(1'b0, v, $sformatf("rndA%0d v=%0d", n, v));
        end

        $display("[TB] T6 no blanking");
        runConversion(1'b1, 32'd42, "T6");
        busRead(1'b1, 4'd5, rd);
        checkOutput("T6 addr5", rd, 32'd0);
        for (int n = 0; n < 4; n++) begin
            v = $urandom_range(0, 99_999_999);
            runConversion(1'b1, v, $sformatf("rndB%0d v=%0d", n, v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
